// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory / MMIO subsystem.
//
// Contents:
//   - Region base and mask constants for RAM and the MMIO block.
//   - Byte offsets of the MMIO registers inside the MMIO block.
//   - Bit positions of the STATUS register fields.
//   - UART serializer state encoding.
package dmem_pkg;

  // RAM starts at zero; its span comes from the RAM_WORDS parameter of the top.
  localparam logic [31:0] RamBase  = 32'h0000_0000;
  // MMIO block is 16 bytes: four word registers.
  localparam logic [31:0] MmioBase = 32'h1000_0000;
  localparam logic [31:0] MmioMask = 32'hFFFF_FFF0;

  localparam logic [3:0] MmioOffTxData  = 4'h0;
  localparam logic [3:0] MmioOffStatus  = 4'h4;
  localparam logic [3:0] MmioOffCycleLo = 4'h8;
  localparam logic [3:0] MmioOffCycleHi = 4'hC;

  localparam int unsigned StatusFullBit     = 0;
  localparam int unsigned StatusEmptyBit    = 1;
  localparam int unsigned StatusBusyBit     = 2;
  localparam int unsigned StatusOverflowBit = 3;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a circular TX FIFO in front of an 8N1 serializer.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset; aborts any frame, empties the FIFO
//   push_i       request to enqueue byte_i this cycle
//   byte_i       byte to enqueue
//   full_o       FIFO holds FIFO_DEPTH entries
//   empty_o      FIFO holds no entries
//   busy_o       serializer is not idle
//   pop_o        serializer takes the head entry this cycle
//   tx_o         registered serial line, idle high
//
// A push while full is accepted only when a pop happens in the same cycle; otherwise
// the byte is dropped (the caller records the overflow).
module uart_tx_fifo
  import dmem_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic [7:0] byte_i,
  output logic       full_o,
  output logic       empty_o,
  output logic       busy_o,
  output logic       pop_o,
  output logic       tx_o
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);

  logic [7:0]      fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push_ok;
  logic            pop;

  uart_state_t      state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;

  assign full_o  = (count_q == CntFull);
  assign empty_o = (count_q == '0);
  assign busy_o  = (state_q != StIdle);
  assign pop     = (state_q == StIdle) && !empty_o;
  // The pop frees a slot in the same cycle, so a push at full still fits.
  assign push_ok = push_i && (!full_o || pop);
  assign pop_o   = pop;
  assign tx_o    = tx_q;

  // FIFO pointer and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push_ok && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push_ok && pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Serializer next state.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          state_d = StStart;
          baud_d  = '0;
          shift_d = fifo_q[rd_ptr_q];
        end
      end
      StStart: begin
        if (baud_q == BaudLast) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = StData;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StData: begin
        if (baud_q == BaudLast) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StStop: begin
        if (baud_q == BaudLast) begin
          baud_d  = '0;
          state_d = StIdle;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Line level follows the state being entered so tx_q lines up with state_q.
    tx_d = 1'b1;
    case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_ptr_q] <= byte_i;
  end

endmodule

// File: rtl/dmem_mmio_ctrl.sv
// Data-memory subsystem behind the core's load/store stage: word RAM plus an MMIO
// block holding a UART transmitter and a 64-bit cycle counter. Load data is
// combinational so the MEM-WB register can sample it in the same cycle.
//
// Ports:
//   clk                    system clock
//   rst                    synchronous active-high reset
//   i_data_mem_addr        byte address; [1:0] ignored unless misalign checking is built in
//   i_data_mem_write_data  store data
//   i_data_mem_read_en     load request this cycle
//   i_data_mem_write_en    store request this cycle (wins over a simultaneous load)
//   o_data_mem_read_data   combinational load data, 0 when no load is performed
//   o_misaligned           (DMEM_MISALIGN_CHECK_EN only) one-cycle pulse after a
//                          misaligned access
//   o_uart_tx              serial TX line, idle high
//
// Build option: define DMEM_MISALIGN_CHECK_EN to suppress misaligned accesses and
// flag them on o_misaligned.
module dmem_mmio_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned RAM_WORDS    = 1024,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_data_mem_addr,
  input  logic [31:0] i_data_mem_write_data,
  input  logic        i_data_mem_read_en,
  input  logic        i_data_mem_write_en,
  output logic [31:0] o_data_mem_read_data,
`ifdef DMEM_MISALIGN_CHECK_EN
  output logic        o_misaligned,
`endif
  output logic        o_uart_tx
);

  localparam int unsigned RamAw = $clog2(RAM_WORDS);
  localparam logic [31:0] RamMask = ~((32'(RAM_WORDS) << 2) - 32'd1);

  logic misaligned;
`ifdef DMEM_MISALIGN_CHECK_EN
  assign misaligned = |i_data_mem_addr[1:0];
`else
  logic unused_addr_lsbs;
  assign misaligned       = 1'b0;
  assign unused_addr_lsbs = ^i_data_mem_addr[1:0];
`endif

  logic             wr_en;
  logic             rd_en;
  logic             ram_sel;
  logic             mmio_sel;
  logic [3:0]       mmio_off;
  logic [RamAw-1:0] word_idx;

  // A simultaneous load+store is treated as a store only.
  assign wr_en    = i_data_mem_write_en & ~misaligned;
  assign rd_en    = i_data_mem_read_en & ~i_data_mem_write_en & ~misaligned;
  assign ram_sel  = ((i_data_mem_addr & RamMask) == RamBase);
  assign mmio_sel = ((i_data_mem_addr & MmioMask) == MmioBase);
  assign mmio_off = {i_data_mem_addr[3:2], 2'b00};
  assign word_idx = i_data_mem_addr[RamAw+1:2];

  // Word RAM: synchronous write, asynchronous read (old data on read-during-write).
  logic [31:0] ram_q [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en && ram_sel) ram_q[word_idx] <= i_data_mem_write_data;
  end

  // MMIO strobes.
  logic tx_push;
  logic status_write;
  logic lo_read;

  assign tx_push      = wr_en & mmio_sel & (mmio_off == MmioOffTxData);
  assign status_write = wr_en & mmio_sel & (mmio_off == MmioOffStatus);
  assign lo_read      = rd_en & mmio_sel & (mmio_off == MmioOffCycleLo);

  logic tx_full;
  logic tx_empty;
  logic tx_busy;
  logic tx_pop;

  uart_tx_fifo #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (tx_push),
    .byte_i (i_data_mem_write_data[7:0]),
    .full_o (tx_full),
    .empty_o(tx_empty),
    .busy_o (tx_busy),
    .pop_o  (tx_pop),
    .tx_o   (o_uart_tx)
  );

  // Cycle counter with a high-half shadow captured on every CYCLE_LO load, so a
  // LO-then-HI read pair is consistent across a carry out of the low half.
  logic [63:0] cycle_q;
  logic [31:0] cycle_hi_shadow_q;
  logic        overflow_q, overflow_d;

  // A dropped push outranks a same-cycle clear so no overflow event is lost.
  always_comb begin
    overflow_d = overflow_q;
    if (tx_push && tx_full && !tx_pop) begin
      overflow_d = 1'b1;
    end else if (status_write) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q           <= '0;
      cycle_hi_shadow_q <= '0;
      overflow_q        <= 1'b0;
    end else begin
      cycle_q    <= cycle_q + 64'd1;
      overflow_q <= overflow_d;
      if (lo_read) cycle_hi_shadow_q <= cycle_q[63:32];
    end
  end

  // Load data mux.
  logic [31:0] status_word;

  always_comb begin
    status_word                    = '0;
    status_word[StatusFullBit]     = tx_full;
    status_word[StatusEmptyBit]    = tx_empty;
    status_word[StatusBusyBit]     = tx_busy;
    status_word[StatusOverflowBit] = overflow_q;

    o_data_mem_read_data = '0;
    if (rd_en) begin
      if (ram_sel) begin
        o_data_mem_read_data = ram_q[word_idx];
      end else if (mmio_sel) begin
        case (mmio_off)
          MmioOffStatus:  o_data_mem_read_data = status_word;
          MmioOffCycleLo: o_data_mem_read_data = cycle_q[31:0];
          MmioOffCycleHi: o_data_mem_read_data = cycle_hi_shadow_q;
          default:        o_data_mem_read_data = '0;
        endcase
      end
    end
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  logic misaligned_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= (i_data_mem_read_en | i_data_mem_write_en) & misaligned;
    end
  end

  assign o_misaligned = misaligned_q;
`endif

endmodule

// File: doc/dmem_mmio_ctrl.md
Name: dmem_mmio_ctrl

Overview:
Data-memory subsystem downstream of the core's load/store stage. Consumes the core's single-cycle data-memory request signals and returns read data combinationally in the same cycle, so the MEM-WB register samples it directly. Decodes word RAM plus a small MMIO block: a UART transmitter with TX FIFO, and a 64-bit cycle counter with a snapshot-consistent high half.

Parameters:
RAM_WORDS, 1024, depth of internal word RAM (power of two)
FIFO_DEPTH, 8, UART TX FIFO entries (power of two, >=2)
CLKS_PER_BIT, 868, clk cycles per UART bit (>=2)

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock, synchronous, active-high
i_data_mem_addr  in  32  byte address from core; [1:0] ignored (word access only)
i_data_mem_write_data  in  32  store data
i_data_mem_read_en  in  1  load request, this cycle
i_data_mem_write_en  in  1  store request, this cycle
o_data_mem_read_data  out  32  combinational load data
o_uart_tx  out  1  serial TX line, idle high

Behaviour:
- Memory map:
  - RAM at 0x0000_0000 .. 4*RAM_WORDS-1, indexed by addr[log2(RAM_WORDS)+1:2]
  - 0x1000_0000 TXDATA (W: push byte [7:0]; R: 0)
  - 0x1000_0004 STATUS (R: bit0 full, bit1 empty, bit2 busy, bit3 overflow; W any value: clear overflow)
  - 0x1000_0008 CYCLE_LO; 0x1000_000C CYCLE_HI
  - Anything else unmapped: reads 0, writes ignored.
- RAM: write on rising clk when write_en is asserted. Read is combinational. Read-during-write to the same word returns the old word. RAM contents are not reset.
- read_en=0 -> read_data=0. If read_en and write_en are both 1, the access is a write and read_data=0.
- Cycle counter:
  - 64-bit, +1 every cycle, wraps 2^64-1 -> 0.
  - A read of CYCLE_LO returns the low half and copies the current high half into a shadow register on that clock edge.
  - CYCLE_HI returns the shadow.
- UART FIFO:
  - Circular buffer with wr/rd pointers and a count of width log2(FIFO_DEPTH)+1.
  - Push on a TXDATA write when not full.
  - Push when full: byte dropped, overflow set (sticky). Exception: a pop in the same cycle frees a slot, so the push is accepted and count is unchanged.
  - Overflow-set and STATUS-clear in the same cycle: set wins.
- Serializer FSM IDLE -> START -> DATA -> STOP -> IDLE:
  - IDLE with FIFO non-empty: pop, load shift register, go to START next cycle.
  - START drives 0. DATA drives 8 bits LSB first. STOP drives 1. Each state/bit lasts exactly CLKS_PER_BIT cycles, timed by a baud counter.
  - From STOP, go directly to IDLE. Back-to-back frames are therefore separated by exactly one IDLE cycle.
  - busy = state != IDLE.
- Reset values:
  - o_uart_tx=1, FSM IDLE, FIFO empty (pointers/count 0), overflow 0, cycle counter 0, shadow 0.
  - o_data_mem_read_data follows the combinational rule (0 while read_en=0).
  - Reset mid-frame aborts the frame immediately: line returns to 1 on the next cycle and the FIFO contents are discarded.

Optional Feature:
DMEM_MISALIGN_CHECK_EN:
- Defined:
  - Adds output o_misaligned (1 bit), a one-cycle pulse registered on the edge after any read_en/write_en access with addr[1:0]!=0.
  - Misaligned writes are suppressed (no RAM/MMIO side effect).
  - Misaligned reads return 0.
  - o_misaligned resets to 0.
- Undefined: no port exists; addr[1:0] is silently ignored.

Decomposition:
- Package dmem_pkg:
  - region base/mask constants
  - MMIO offsets (TXDATA, STATUS, CYCLE_LO, CYCLE_HI)
  - STATUS bit-index constants
  - enum uart_state_t {IDLE, START, DATA, STOP}
- One sub-module, uart_tx_fifo: FIFO plus serializer, exposing push/byte/full/empty/busy/tx.
- Top level keeps the decode, RAM, cycle counter, shadow and overflow flag.

Test Plan:
- Write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 the next cycle -> read_data=0xDEADBEEF. Read 0x0000_0014 -> 0 (after preload 0). Read 0x2000_0000 -> 0.
- CLKS_PER_BIT=4, write 0x41 to TXDATA:
  - o_uart_tx stays 1 one cycle after the push edge, then shows 4 cycles 0, bits 1,0,0,0,0,0,1,0 (4 cycles each), then 4 cycles 1.
  - STATUS bit2 is 1 during the frame and 0 after.
- FIFO_DEPTH=8, CLKS_PER_BIT=16, nine TXDATA writes on consecutive cycles:
  - first byte pops, the 8 following fill the FIFO, STATUS reads full=1, overflow=0
  - a tenth write sets overflow=1 and its byte is never transmitted
  - write to STATUS -> overflow=0
- Force counter to 0x0000_0001_FFFF_FFFF, read CYCLE_LO then CYCLE_HI on the next cycle -> LO=0xFFFFFFFF, HI=0x00000001 (not 2).
- Assert rst mid-DATA of a frame with 3 bytes queued -> o_uart_tx=1 the next cycle, STATUS=empty(bit1)=1, no further frames.
- With DMEM_MISALIGN_CHECK_EN: write 0x12345678 to 0x0000_0022 -> o_misaligned pulses exactly 1 cycle, and word 0x0000_0020 is unchanged.
